// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer wrapping a combinational ALU: IDLE->EXEC->WB.
// Optional ALU_ISSUE_SATFLAG_EN flags clamp-valued writeback results.
module alu_issue_seq #(
  parameter int N  = 16,
  parameter int C  = 6,
  parameter int S  = 5,
  parameter int RA = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [C+3*RA+S-1:0]   instr,
  input  logic [N-1:0]          instr_imm,
  input  logic                  ld_valid,
  input  logic [RA-1:0]         ld_addr,
  input  logic [N-1:0]          ld_data,
  input  logic [RA-1:0]         rd_addr,
  output logic [N-1:0]          rd_data,
  output logic [C-1:0]          alu_opcode,
  output logic [N-1:0]          alu_a,
  output logic [N-1:0]          alu_b,
  output logic [S-1:0]          alu_shift,
  input  logic [N-1:0]          alu_y,
  output logic                  done,
  output logic                  illegal,
  output logic                  sat_flag
);

  localparam int IW = C + 3*RA + S;
  localparam int D  = 1 << RA;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_e;

  function automatic logic is_imm(
    input logic [C-1:0] op
  );
    case (int'(op))
      2, 4, 6, 8, 10,
      12, 16, 18, 20: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic is_wr(
    input logic [C-1:0] op
  );
    return ((int'(op) >= 1)  &&
            (int'(op) <= 12)) ||
           ((int'(op) >= 15) &&
            (int'(op) <= 26));
  endfunction

  logic [C-1:0]  f_op;
  logic [RA-1:0] f_rd;
  logic [RA-1:0] f_ra;
  logic [RA-1:0] f_rb;
  logic [S-1:0]  f_sh;

  assign f_op = instr[IW-1 -: C];
  assign f_rd = instr[S+3*RA-1 -: RA];
  assign f_ra = instr[S+2*RA-1 -: RA];
  assign f_rb = instr[S+RA-1 -: RA];
  assign f_sh = instr[S-1:0];

  state_e        state_q, state_d;
  logic [N-1:0]  rf_q [D];
  logic [N-1:0]  rf_d [D];
  logic [C-1:0]  opc_q, opc_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [S-1:0]  sh_q, sh_d;
  logic [RA-1:0] rd_q, rd_d;
  logic [N-1:0]  res_q, res_d;
  logic          done_q, done_d;
  logic          ill_q, ill_d;
  logic          accept;
  logic          ex_wr;
  logic          ex_nop;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign ex_wr       = is_wr(opc_q);
  assign ex_nop      = (opc_q == '0);

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    res_d   = res_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opc_d   = f_op;
          a_d     = rf_q[f_ra];
          b_d     = is_imm(f_op) ?
                    instr_imm :
                    rf_q[f_rb];
          sh_d    = f_sh;
          rd_d    = f_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_y;
        done_d  = ex_wr || ex_nop;
        ill_d   = !(ex_wr || ex_nop);
        state_d = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // External load first so a same-address writeback overrides it.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (ld_valid) begin
      rf_d[ld_addr] = ld_data;
    end
    if ((state_q == WB) && ex_wr) begin
      rf_d[rd_q] = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < D; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      for (int i = 0; i < D; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef ALU_ISSUE_SATFLAG_EN
  logic sat_q, sat_d;

  // A NOP may carry X on alu_y; the write gate masks it.
  always_comb begin
    sat_d = 1'b0;
    if ((state_q == EXEC) && ex_wr) begin
      sat_d = (alu_y == N'('h7FFF)) ||
              (alu_y == N'('hFFFF));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign rd_data    = rf_q[rd_addr];
  assign alu_opcode = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_shift  = sh_q;
  assign done       = done_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with a stub ALU and a
// register-file reference model.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [19:0] instr = '0;
  logic [15:0] instr_imm = '0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_y = '0;
  logic        done;
  logic        illegal;
  logic        sat_flag;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] m [8];

  alu_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_imm   (instr_imm),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shift   (alu_shift),
    .alu_y       (alu_y),
    .done        (done),
    .illegal     (illegal),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit m_wr(input int op);
    return (op >= 1 && op <= 12) || (op >= 15 && op <= 26);
  endfunction

  function automatic bit m_imm(input int op);
    return op inside {2, 4, 6, 8, 10, 12, 16, 18, 20};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    cyc();
    ld_valid = 1'b0;
    m[a]     = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(tag, rd_data, m[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] ra,
                       input logic [2:0] rb,
                       input logic [4:0] sh,
                       input logic [15:0] imm,
                       input logic [15:0] y,
                       input bit coll,
                       input logic [15:0] cd);
    bit          wr;
    bit          nop;
    bit          es;
    logic [15:0] eb;
    wr  = m_wr(int'(op));
    nop = (op == 6'd0);
    eb  = m_imm(int'(op)) ? imm : m[rb];
    es  = 1'b0;
`ifdef ALU_ISSUE_SATFLAG_EN
    if (wr) es = (y == 16'h7FFF) || (y == 16'hFFFF);
`endif
    chk("ready_idle", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = {op, rd, ra, rb, sh};
    instr_imm   = imm;
    cyc();
    instr_valid = 1'b0;
    instr       = 20'($urandom);
    instr_imm   = 16'($urandom);
    chk("alu_opcode", alu_opcode, op);
    chk("alu_a", alu_a, m[ra]);
    chk("alu_b", alu_b, eb);
    chk("alu_shift", alu_shift, sh);
    chk("ready_exec", instr_ready, 1'b0);
    chk("done_exec", done, 1'b0);
    alu_y = y;
    cyc();
    alu_y = 16'($urandom);
    chk("ready_wb", instr_ready, 1'b0);
    chk("done_wb", done, wr || nop);
    chk("illegal_wb", illegal, !(wr || nop));
    chk("sat_wb", sat_flag, es);
    if (coll) begin
      ld_valid = 1'b1;
      ld_addr  = rd;
      ld_data  = cd;
    end
    cyc();
    ld_valid = 1'b0;
    if (wr) m[rd] = y;
    else if (coll) m[rd] = cd;
    chk("done_after", done, 1'b0);
    chk("illegal_after", illegal, 1'b0);
    chk("sat_after", sat_flag, 1'b0);
    chk("ready_after", instr_ready, 1'b1);
    rd_addr = rd;
    #1;
    chk("rd_result", rd_data, m[rd]);
  endtask

  initial begin
    logic [5:0]  op;
    logic [15:0] y;
    logic [15:0] h;

    foreach (m[i]) m[i] = '0;

    #12;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_sat", sat_flag, 1'b0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_alu_b", alu_b, 16'h0);
    chk("rst_alu_op", alu_opcode, 6'h0);
    chk("rst_alu_sh", alu_shift, 5'h0);
    rst_n = 1'b1;
    cyc();
    sweep("rst_regs");

    // ADD_I r2 = r1 + imm
    ld(3'd1, 16'h0003);
    issue(6'd2, 3'd2, 3'd1, 3'd0, 5'd0, 16'h0004, 16'h0007, 0, '0);
    // AND r5 = r3 & r4, register path
    ld(3'd3, 16'h00F0);
    ld(3'd4, 16'h0F0F);
    issue(6'd15, 3'd5, 3'd3, 3'd4, 5'd3, 16'hBEEF, 16'h0000, 0, '0);
    // illegal opcode 14 leaves r6 alone, then NOP
    ld(3'd6, 16'h1234);
    issue(6'd14, 3'd6, 3'd1, 3'd2, 5'd0, 16'h0, 16'h9999, 0, '0);
    issue(6'd0, 3'd6, 3'd1, 3'd2, 5'd0, 16'h0, 16'hxxxx, 0, '0);
    issue(6'd27, 3'd6, 3'd1, 3'd2, 5'd0, 16'h0, 16'h1111, 0, '0);
    issue(6'd26, 3'd7, 3'd1, 3'd2, 5'd7, 16'h0, 16'h2222, 0, '0);

    // back-to-back with instr_valid held, dependent operand
    ld(3'd1, 16'h0005);
    instr_valid = 1'b1;
    instr       = {6'd1, 3'd3, 3'd1, 3'd1, 5'd0};
    instr_imm   = '0;
    cyc();
    chk("b2b_ready_exec", instr_ready, 1'b0);
    chk("b2b_a1", alu_a, 16'h0005);
    instr = {6'd1, 3'd4, 3'd3, 3'd3, 5'd0};
    alu_y = 16'h000A;
    cyc();
    chk("b2b_ready_wb", instr_ready, 1'b0);
    chk("b2b_done1", done, 1'b1);
    cyc();
    m[3] = 16'h000A;
    chk("b2b_ready_idle", instr_ready, 1'b1);
    chk("b2b_hold_a", alu_a, 16'h0005);
    cyc();
    instr_valid = 1'b0;
    chk("b2b_ready2", instr_ready, 1'b0);
    chk("b2b_a2_dep", alu_a, 16'h000A);
    chk("b2b_b2_dep", alu_b, 16'h000A);
    alu_y = 16'h0014;
    cyc();
    chk("b2b_done2", done, 1'b1);
    cyc();
    m[4] = 16'h0014;
    sweep("b2b_regs");

    // load collides with writeback: writeback wins; non-writing loses nothing
    issue(6'd1, 3'd2, 3'd1, 3'd1, 5'd0, 16'h0, 16'h5555, 1, 16'hAAAA);
    issue(6'd13, 3'd2, 3'd1, 3'd1, 5'd0, 16'h0, 16'h7777, 1, 16'hAAAA);

    // clamp values
    issue(6'd1, 3'd5, 3'd1, 3'd2, 5'd0, 16'h0, 16'h7FFF, 0, '0);
    issue(6'd1, 3'd5, 3'd1, 3'd2, 5'd0, 16'h0, 16'h7FFE, 0, '0);
    issue(6'd4, 3'd6, 3'd1, 3'd2, 5'd0, 16'h1, 16'hFFFF, 0, '0);
    issue(6'd14, 3'd6, 3'd1, 3'd2, 5'd0, 16'h1, 16'hFFFF, 0, '0);

    // reset in EXEC drops the instruction
    instr_valid = 1'b1;
    instr       = {6'd1, 3'd0, 3'd1, 3'd1, 5'd0};
    cyc();
    instr_valid = 1'b0;
    alu_y = 16'h4321;
    chk("midrst_exec", instr_ready, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", instr_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_alu_a", alu_a, 16'h0);
    rst_n = 1'b1;
    foreach (m[i]) m[i] = '0;
    cyc();
    chk("midrst_done2", done, 1'b0);
    cyc();
    chk("midrst_done3", done, 1'b0);
    sweep("midrst_regs");

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        ld(3'($urandom), 16'($urandom));
      op = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        op = 6'($urandom_range(1, 26));
      h = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       y = 16'h7FFF;
        1:       y = 16'hFFFF;
        default: y = 16'($urandom);
      endcase
      if (op == 6'd0) y = 16'hxxxx;
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom),
            5'($urandom), h, y,
            ($urandom_range(0, 3) == 0), 16'($urandom));
    end
    sweep("final_regs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
